// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : core_sequencer
// Brief   : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for an RV32I core.
// Revision: 1.0
// ============================================================================
module core_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        ctrl_rf_wen,
    output logic [31:0] instr,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] retired
);

    localparam int unsigned   c_cnt_w   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(MEM_TIMEOUT);

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_FAULT   = 3'd7
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        retired_q, retired_d;
    logic [1:0]         fault_code_q, fault_code_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;

    logic [6:0] w_opcode;
    logic       w_legal;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_is_system;

    assign w_opcode    = instr_q[6:0];
    assign w_is_load   = (w_opcode == c_op_load);
    assign w_is_store  = (w_opcode == c_op_store);
    assign w_is_branch = (w_opcode == c_op_branch);
    assign w_is_system = (w_opcode == c_op_system);

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            c_op_rtype, c_op_itype, c_op_load, c_op_store, c_op_branch,
            c_op_jal, c_op_jalr, c_op_lui, c_op_auipc, c_op_system: w_legal = 1'b1;
            default: w_legal = 1'b0;
        endcase
    end

    // The wait counter rests at zero outside FETCH/MEM, so each entry starts fresh.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        retired_d    = retired_q;
        fault_code_d = fault_code_q;
        cnt_d        = '0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_wen       = 1'b0;
        pc_wen       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (cnt_q == c_timeout) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!w_legal) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd2;
                end else if (w_is_system) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = (w_is_load || w_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (cnt_q == c_timeout) begin
                    state_d      = S_FAULT;
                    fault_code_d = 2'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB: begin
                pc_wen    = 1'b1;
                rf_wen    = ctrl_rf_wen && !w_is_store && !w_is_branch;
                retired_d = retired_q + 32'd1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT, S_FAULT: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            instr_q      <= NOP_INSTR;
            retired_q    <= '0;
            fault_code_q <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            retired_q    <= retired_d;
            fault_code_q <= fault_code_d;
            cnt_q        <= cnt_d;
        end
    end

    assign instr      = instr_q;
    assign state      = state_q;
    assign retired    = retired_q;
    assign fault_code = fault_code_q;
    assign halted     = (state_q == S_HALT);
    assign fault      = (state_q == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_core_sequencer
// Brief   : Scoreboard bench for core_sequencer; per-cycle expected state and
//           strobe vectors are queued per scenario and compared at negedge.
// Revision: 1.0
// ============================================================================
module tb_core_sequencer;

    localparam int unsigned TO    = 4;
    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADDI  = 32'h00500093;
    localparam logic [31:0] LW    = 32'h0000A103;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] ECALL = 32'h00000073;
    localparam logic [31:0] BAD   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst, run, imem_ready, dmem_ready, ctrl_rf_wen;
    logic [31:0] imem_rdata, instr, retired;
    logic        imem_req, dmem_req, dmem_we, rf_wen, pc_wen, halted, fault;
    logic [2:0]  state;
    logic [1:0]  fault_code;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];

    core_sequencer #(.MEM_TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .ctrl_rf_wen(ctrl_rf_wen), .instr(instr), .rf_wen(rf_wen), .pc_wen(pc_wen),
        .state(state), .halted(halted), .fault(fault), .fault_code(fault_code),
        .retired(retired)
    );

    always #5 clk = ~clk;

    // {state, imem_req, dmem_req, dmem_we, rf_wen, pc_wen, halted, fault}
    function automatic logic [9:0] ev(input logic [2:0] st, input logic we, input logic rfw);
        return {st, st == 3'd1, st == 3'd4, we, rfw, st == 3'd5, st == 3'd6, st == 3'd7};
    endfunction

    function automatic logic [9:0] obs();
        return {state, imem_req, dmem_req, dmem_we, rf_wen, pc_wen, halted, fault};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        ctrl_rf_wen = 1'b0; imem_rdata = '0;
        #1;
        got = obs();
        checks++;
        if (got !== ev(3'd0, 1'b0, 1'b0)) begin
            errors++; $display("FAIL reset_vec got %b exp %b", got, ev(3'd0, 1'b0, 1'b0));
        end
        checks++;
        if (instr !== NOP || retired !== 32'd0 || fault_code !== 2'd0) begin
            errors++; $display("FAIL reset_regs got instr %h ret %0d fc %0d", instr, retired, fault_code);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addi();
        logic [9:0] got, exp_v;
        logic [2:0] seq [9];
        seq = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0};
        for (int k = 0; k < 9; k++) sb.push_back(ev(seq[k], 1'b0, seq[k] == 3'd5));
        run = 1'b1; imem_ready = 1'b1; imem_rdata = ADDI; ctrl_rf_wen = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL addi cyc%0d got %b exp %b", i, got, exp_v);
            end
            if (i == 1) begin
                checks++;
                if (instr !== ADDI) begin errors++; $display("FAIL addi_instr got %h exp %h", instr, ADDI); end
            end
            if (i == 4) begin
                checks++;
                if (retired !== 32'd1) begin errors++; $display("FAIL addi_retired got %0d exp 1", retired); end
            end
            if (i == 5) run = 1'b0;
        end
        checks++;
        if (retired !== 32'd2) begin errors++; $display("FAIL runstop_retired got %0d exp 2", retired); end
    endtask

    task automatic test_store();
        logic [9:0] got, exp_v;
        logic [2:0] seq [6];
        seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        for (int k = 0; k < 6; k++) sb.push_back(ev(seq[k], seq[k] == 3'd4, 1'b0));
        run = 1'b1; imem_ready = 1'b1; imem_rdata = SW; ctrl_rf_wen = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL store cyc%0d got %b exp %b", i, got, exp_v);
            end
            if (i == 3) run = 1'b0;
        end
        checks++;
        if (retired !== 32'd3) begin errors++; $display("FAIL store_retired got %0d exp 3", retired); end
    endtask

    task automatic test_load();
        logic [9:0] got, exp_v;
        logic [2:0] seq [9];
        seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
        for (int k = 0; k < 9; k++) sb.push_back(ev(seq[k], 1'b0, seq[k] == 3'd5));
        run = 1'b1; imem_ready = 1'b1; imem_rdata = LW; ctrl_rf_wen = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL load cyc%0d got %b exp %b", i, got, exp_v);
            end
            dmem_ready = (i == 6);
            run        = (i < 7);
        end
        checks++;
        if (retired !== 32'd4) begin errors++; $display("FAIL load_retired got %0d exp 4", retired); end
    endtask

    // Ready arrives in exactly the cycle the wait counter hits TO, in FETCH then MEM.
    task automatic test_ready_at_expiry();
        logic [9:0] got, exp_v;
        logic [2:0] seq [14];
        seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3,
                3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd0};
        for (int k = 0; k < 14; k++) sb.push_back(ev(seq[k], 1'b0, seq[k] == 3'd5));
        run = 1'b1; imem_ready = 1'b0; imem_rdata = LW; ctrl_rf_wen = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL expiry cyc%0d got %b exp %b", i, got, exp_v);
            end
            imem_ready = (i == 4);
            dmem_ready = (i == 11);
            run        = (i < 12);
        end
        checks++;
        if (retired !== 32'd5) begin errors++; $display("FAIL expiry_retired got %0d exp 5", retired); end
    endtask

    task automatic test_halt();
        logic [9:0] got, exp_v;
        logic [2:0] seq [5];
        seq = '{3'd1, 3'd2, 3'd6, 3'd6, 3'd6};
        for (int k = 0; k < 5; k++) sb.push_back(ev(seq[k], 1'b0, 1'b0));
        run = 1'b1; imem_ready = 1'b1; imem_rdata = ECALL; ctrl_rf_wen = 1'b1; dmem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL halt cyc%0d got %b exp %b", i, got, exp_v);
            end
        end
        checks++;
        if (retired !== 32'd5) begin errors++; $display("FAIL halt_retired got %0d exp 5", retired); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] got, exp_v;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        got = obs(); checks++;
        if (got !== ev(3'd0, 1'b0, 1'b0)) begin
            errors++; $display("FAIL rst_halt_vec got %b exp %b", got, ev(3'd0, 1'b0, 1'b0));
        end
        checks++;
        if (instr !== NOP || retired !== 32'd0) begin
            errors++; $display("FAIL rst_halt_regs got instr %h ret %0d exp %h 0", instr, retired, NOP);
        end
        @(negedge clk);
        rst = 1'b0; run = 1'b1; imem_ready = 1'b1; imem_rdata = LW; dmem_ready = 1'b0;
        sb.push_back(ev(3'd4, 1'b0, 1'b0));
        repeat (4) @(negedge clk);
        got = obs(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin errors++; $display("FAIL rst_pre_mem got %b exp %b", got, exp_v); end
        #2 rst = 1'b1;
        #1;
        got = obs(); checks++;
        if (got !== ev(3'd0, 1'b0, 1'b0)) begin
            errors++; $display("FAIL rst_mem_vec got %b exp %b", got, ev(3'd0, 1'b0, 1'b0));
        end
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
    endtask

    task automatic test_fetch_timeout();
        logic [9:0] got, exp_v;
        logic [2:0] seq [7];
        seq = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd7, 3'd7};
        do_reset();
        for (int k = 0; k < 7; k++) sb.push_back(ev(seq[k], 1'b0, 1'b0));
        run = 1'b1; imem_ready = 1'b0; imem_rdata = ADDI; dmem_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL timeout cyc%0d got %b exp %b", i, got, exp_v);
            end
        end
        checks++;
        if (fault_code !== 2'd1) begin errors++; $display("FAIL timeout_code got %0d exp 1", fault_code); end
    endtask

    task automatic test_illegal();
        logic [9:0] got, exp_v;
        logic [2:0] seq [4];
        seq = '{3'd1, 3'd2, 3'd7, 3'd7};
        do_reset();
        for (int k = 0; k < 4; k++) sb.push_back(ev(seq[k], 1'b0, 1'b0));
        run = 1'b1; imem_ready = 1'b1; imem_rdata = BAD; dmem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = obs(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                errors++; $display("FAIL illegal cyc%0d got %b exp %b", i, got, exp_v);
            end
        end
        checks++;
        if (fault_code !== 2'd2 || retired !== 32'd0) begin
            errors++; $display("FAIL illegal_code got fc %0d ret %0d exp 2 0", fault_code, retired);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_load();
        test_ready_at_expiry();
        test_halt();
        test_reset_mid();
        test_fetch_timeout();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
